// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the store path: sequencer state encoding, store size
// codes, store_control_sign codes and small decode helpers.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Sequencer states (3-bit encoding).
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    // store_size codes; 2'b11 is reserved and behaves as a word store.
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // store_control_sign codes, {partial, half}.
    localparam logic [1:0] SCS_WORD = 2'b00;
    localparam logic [1:0] SCS_HALF = 2'b11;
    localparam logic [1:0] SCS_BYTE = 2'b10;

    // True for sizes that need a read-modify-write (half and byte).
    function automatic logic is_partial(input logic [1:0] sz);
        return (sz == SZ_HALF) || (sz == SZ_BYTE);
    endfunction

    function automatic logic [1:0] scs_for_size(input logic [1:0] sz);
        logic [1:0] scs;
        case (sz)
            SZ_HALF: scs = SCS_HALF;
            SZ_BYTE: scs = SCS_BYTE;
            default: scs = SCS_WORD;
        endcase
        return scs;
    endfunction

    // Alignment rule: word needs addr[1:0]=00, half needs addr[0]=0,
    // byte is always aligned.
    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] addr_lo);
        logic ok;
        case (sz)
            SZ_HALF: ok = (addr_lo[0] == 1'b0);
            SZ_BYTE: ok = 1'b1;
            default: ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_sequencer_latency_counter.sv
// ---------------------------------------------------------------------------
// latency_counter
// Counts READ cycles for the store sequencer. Cleared on READ entry, advances
// while enabled, and saturates at READ_LATENCY-1 so it never wraps.
//
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   clear_i  synchronous clear to 0 (takes priority over enable)
//   en_i     count enable
//   tc_o     terminal count, high while count == READ_LATENCY-1
// ---------------------------------------------------------------------------
module latency_counter #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(READ_LATENCY - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/store_sequencer.sv
// ---------------------------------------------------------------------------
// store_sequencer
// Multicycle store sequencer between the control unit and data memory.
// Sub-word stores (sb/sh) read the target word into the MDR, present it with
// store_control_sign to store_control, then pulse the memory write. Word
// stores skip the read and write directly. Misaligned requests produce a
// one-cycle misaligned pulse and no write.
//
// Parameters:
//   READ_LATENCY        cycles from address valid to mem_rdata valid (>=1)
// Ports:
//   clk                 system clock
//   reset               asynchronous active-high reset
//   start               store request, sampled only in IDLE
//   store_size          00 word, 01 half, 10 byte, 11 treated as word
//   addr                byte address, held stable by caller while busy
//   mem_rdata           data-memory read data
//   mem_wr              data-memory write enable (one cycle per store)
//   mdr_data            MDR contents (word read back) for store_control
//   store_control_sign  {partial, half}: word 00, half 11, byte 10
//   busy                high whenever not IDLE
//   done                one-cycle completion pulse
//   misaligned          one-cycle error pulse, no write performed
// ---------------------------------------------------------------------------
module store_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_size,
    input  logic [31:0] addr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr,
    output logic [31:0] mdr_data,
    output logic [1:0]  store_control_sign,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    state_e      state_q;
    logic [1:0]  size_q;
    logic [31:0] mdr_q;
    logic        mem_wr_q;
    logic        busy_q;
    logic        done_q;
    logic        mis_q;

    logic        req_aligned;
    logic        cnt_clear;
    logic        cnt_en;
    logic        cnt_tc;

    // Only the two low address bits matter for alignment.
    logic        addr_hi_unused;
    assign addr_hi_unused = ^addr[31:2];

    assign req_aligned = is_aligned(store_size, addr[1:0]);

    // Clear on the edge that enters READ so the first READ cycle counts 0.
    assign cnt_clear = (state_q == S_IDLE) && start && req_aligned && is_partial(store_size);
    assign cnt_en    = (state_q == S_READ);

    latency_counter #(
        .READ_LATENCY (READ_LATENCY)
    ) u_latency_counter (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tc_o    (cnt_tc)
    );

    // Outputs are registered alongside the state so each one is a clean
    // Moore decode of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            size_q   <= SZ_WORD;
            mdr_q    <= '0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        size_q <= store_size;
                        busy_q <= 1'b1;
                        if (!req_aligned) begin
                            state_q <= S_ERR;
                            mis_q   <= 1'b1;
                        end else if (is_partial(store_size)) begin
                            state_q <= S_READ;
                        end else begin
                            state_q  <= S_WRITE;
                            mem_wr_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (cnt_tc) begin
                        mdr_q    <= mem_rdata;
                        state_q  <= S_WRITE;
                        mem_wr_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    mem_wr_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    mis_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    mem_wr_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    mis_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_wr             = mem_wr_q;
    assign mdr_data           = mdr_q;
    assign store_control_sign = scs_for_size(size_q);
    assign busy               = busy_q;
    assign done               = done_q;
    assign misaligned         = mis_q;

endmodule

// File: doc/store_sequencer.md
# store_sequencer

Multicycle store sequencer sitting between the control unit and data memory, directly upstream of `store_control`. For `sb`/`sh` it performs the read-modify-write: reads the target word, holds it in its MDR register and feeds `mdr_data` plus `store_control_sign` to `store_control`. It then asserts the memory write for the merged word. For `sw` it skips the read and writes `B` directly.

## Interface
Parameters:
- `READ_LATENCY`, default 1: cycles from address valid to `mem_rdata` valid. Legal values are ≥1.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock.
- `start`  in  1  store request from control unit; sampled only in IDLE.
- `store_size`  in  2  `00` word, `01` half, `10` byte, `11` reserved (treated as word).
- `addr`  in  32  byte address of the store; held stable by the caller while `busy`.
- `mem_rdata`  in  32  data-memory read port.
- `mem_wr`  out  1  data-memory write enable.
- `mdr_data`  out  32  MDR contents, i.e. the word read back; goes to `store_control`.
- `store_control_sign`  out  2  `{partial, half}`: word `00`, half `11`, byte `10`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  one-cycle error pulse; no write performed.

## Operation
- States: IDLE, READ, WRITE, DONE, ERR. All outputs are Moore, decoded from registered state.
- IDLE + `start`:
  - Latch `store_size` into `size_q` and decode `store_control_sign`.
  - Check alignment. Half requires `addr[0]=0`. Word requires `addr[1:0]=00`. Byte is always aligned.
  - Misaligned → ERR.
  - Word → WRITE.
  - Half/byte → READ, with latency counter cleared to 0.
- READ: counter increments each cycle. When counter = `READ_LATENCY-1`, `mdr_data <= mem_rdata` and state → WRITE.
- WRITE: `mem_wr=1` for exactly one cycle → DONE.
- DONE: `done=1` for one cycle → IDLE.
- ERR: `misaligned=1` for one cycle → IDLE. `mdr_data` is unchanged and `mem_wr` stays 0.
- `start` outside IDLE is ignored; no queuing.
- `mdr_data` changes only on the READ exit edge. A word store leaves the previous MDR value intact.
- `store_control_sign` is held from acceptance until the next accepted `start`.
- Counter width is `$clog2(READ_LATENCY+1)` and it never wraps: it is cleared on READ entry.

## Timing
- Reset values: state IDLE, `mem_wr=0`, `mdr_data=32'h0`, `store_control_sign=2'b00`, `busy=0`, `done=0`, `misaligned=0`, counter 0.
- Reset asserted mid-operation (any state) forces IDLE and clears `mem_wr` asynchronously. The interrupted write does not occur or is truncated; the caller must reissue it.
- Latencies, counting `start` sampled at edge E0:
  - word: `mem_wr` high in cycle after E0; `done` in the following cycle. `done` rises at E0+2.
  - half/byte: READ spans `READ_LATENCY` cycles; MDR loads at edge E0+`READ_LATENCY`; `mem_wr` high for the next cycle; `done` rises at E0+`READ_LATENCY`+2.
  - misaligned: `misaligned` rises at E0+1; `busy` is high for one cycle.
- `mem_rdata` is sampled only on the READ exit edge.
- `mdr_data` and `store_control_sign` are stable throughout WRITE, so `store_control` output is valid for the whole write cycle.
- Back-to-back: `start` may be asserted in the DONE cycle but is ignored. The earliest acceptance is the first IDLE cycle.

## Structure
- Shared package `cpu_pkg`:
  - state encoding localparams: IDLE=0, READ=1, WRITE=2, DONE=3, ERR=4; 3 bits.
  - size codes `SZ_WORD`, `SZ_HALF`, `SZ_BYTE`.
  - `store_control_sign` codes `SCS_WORD`, `SCS_HALF`, `SCS_BYTE`.
- Single sub-module `latency_counter`: clear, enable, terminal-count output at `READ_LATENCY-1`.
- MDR register lives in this block; there is no separate MDR instance for stores.

## Test plan
- `READ_LATENCY=1`, `store_size=00`, `addr=0x10`, `start` → `mem_wr` high one cycle at E0+1, `done` at E0+2, `mdr_data` unchanged, `store_control_sign=00`.
- `READ_LATENCY=3`, `store_size=01`, `addr=0x22`, `mem_rdata=0xAABBCCDD` → READ 3 cycles, `mdr_data=0xAABBCCDD` at E0+3, `mem_wr` at E0+4, `store_control_sign=11`, `done` at E0+5.
- `store_size=10`, `addr=0x13`, `mem_rdata=0x11223344` → accepted (byte always aligned), `store_control_sign=10`, one write, `done` pulse.
- `store_size=01`, `addr=0x21` → `misaligned` pulse at E0+1, `mem_wr` never high, `mdr_data` retains prior value.
- `start` re-pulsed during READ and during DONE → ignored; exactly one `mem_wr` and one `done` per accepted request.
- `reset` asserted mid-READ (`READ_LATENCY=3`, cycle 2) → immediate IDLE, `busy=0`, `mem_wr` never asserted, `mdr_data=0`; a fresh `start` afterwards completes normally.
